// File: rtl/buzzer_scheduler.sv
// Single piezo controller: arbitrates hourly chime, alarm session and key-click,
// sequences pip/beep cadences and generates the tone waveform.
module buzzer_scheduler #(
    parameter int PIP_CYCLES    = 250,
    parameter int BEEP_HALF     = 125,
    parameter int ALARM_SECONDS = 60,
    parameter int CLICK_CYCLES  = 10
) (
    input  logic       _500Hz,
    input  logic       CR,
    input  logic [7:0] Hour,
    input  logic [7:0] Minute,
    input  logic [7:0] Second,
    input  logic [7:0] AlarmHour,
    input  logic [7:0] AlarmMinute,
    input  logic       AlarmEn,
    input  logic       Stop,
    input  logic       KeyPress,
    output logic       Buzzer,
    output logic [1:0] Source,
    output logic       Ringing
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHIME = 2'd1,
        S_ALARM = 2'd2,
        S_CLICK = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic [7:0]  r_sec_q;
    logic        r_primed;
    logic        r_ringing;
    logic [7:0]  r_rcnt;
    logic [15:0] r_cnt;
    logic [1:0]  r_tone;
    logic        r_low;
    logic        r_buzzer;

    logic        w_tick;
    logic        w_chime;
    logic        w_chime_low;
    logic        w_start;
    logic        w_end;
    logic        w_ring_nx;
    logic        w_entry;
    logic [15:0] w_cnt_nx;
    logic [1:0]  w_tone_nx;
    logic        w_low_nx;
    logic        w_buzz_nx;

    // Second-change detection and chime/alarm request decoding
    always_comb begin
        w_tick      = r_primed && (Second != r_sec_q);
        w_chime_low = (Second != 8'h59);
        w_chime     = w_tick && (Minute == 8'h59) &&
                      (Second >= 8'h55) && (Second <= 8'h59);
        w_start     = w_tick && (Second == 8'h00) && AlarmEn &&
                      (Hour == AlarmHour) && (Minute == AlarmMinute);
        w_end       = r_ringing && (Stop || !AlarmEn ||
                      (w_tick && (r_rcnt == 8'(ALARM_SECONDS - 1))));
        w_ring_nx   = w_end ? 1'b0 : (w_start ? 1'b1 : r_ringing);
    end

    // Arbiter next state: chime beats alarm beats click
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_chime)        w_state_nx = S_CHIME;
                else if (w_ring_nx) w_state_nx = S_ALARM;
                else if (KeyPress)  w_state_nx = S_CLICK;
            end
            S_CHIME: begin
                if (w_chime)
                    w_state_nx = S_CHIME;
                else if (r_cnt == 16'(PIP_CYCLES - 1))
                    w_state_nx = w_ring_nx ? S_ALARM : S_IDLE;
            end
            S_ALARM: begin
                if (w_chime)         w_state_nx = S_CHIME;
                else if (!w_ring_nx) w_state_nx = S_IDLE;
            end
            S_CLICK: begin
                if (w_chime)
                    w_state_nx = S_CHIME;
                else if (r_cnt == 16'(CLICK_CYCLES - 1))
                    w_state_nx = S_IDLE;
            end
        endcase
    end

    // Phase counters and next tone sample; a pip restart counts as an entry
    always_comb begin
        w_entry   = (w_state_nx != r_state) || ((r_state == S_CHIME) && w_chime);
        w_low_nx  = w_chime ? w_chime_low : r_low;
        w_tone_nx = w_entry ? 2'd0 : r_tone + 2'd1;
        w_cnt_nx  = r_cnt + 16'd1;
        if (w_entry || (r_state == S_IDLE))
            w_cnt_nx = 16'd0;
        else if ((r_state == S_ALARM) && (r_cnt == 16'(2 * BEEP_HALF - 1)))
            w_cnt_nx = 16'd0;
        w_buzz_nx = 1'b0;
        unique case (w_state_nx)
            S_IDLE:  w_buzz_nx = 1'b0;
            S_CHIME: w_buzz_nx = w_low_nx ? ~w_tone_nx[1] : ~w_tone_nx[0];
            S_ALARM: w_buzz_nx = ~w_tone_nx[0] && (w_cnt_nx < 16'(BEEP_HALF));
            S_CLICK: w_buzz_nx = ~w_tone_nx[0];
        endcase
    end

    // Arbiter state register
    always_ff @(posedge _500Hz or posedge CR) begin
        if (CR) r_state <= S_IDLE;
        else    r_state <= w_state_nx;
    end

    // Second sampler; primed blocks a tick on the first post-reset sample
    always_ff @(posedge _500Hz or posedge CR) begin
        if (CR) begin
            r_sec_q  <= 8'h00;
            r_primed <= 1'b0;
        end else begin
            r_sec_q  <= Second;
            r_primed <= 1'b1;
        end
    end

    // Alarm session flag and its second counter, running even when preempted
    always_ff @(posedge _500Hz or posedge CR) begin
        if (CR) begin
            r_ringing <= 1'b0;
            r_rcnt    <= 8'd0;
        end else begin
            r_ringing <= w_ring_nx;
            if (w_end)
                r_rcnt <= 8'd0;
            else if (w_start)
                r_rcnt <= 8'd0;
            else if (r_ringing && w_tick)
                r_rcnt <= r_rcnt + 8'd1;
        end
    end

    // Tone generator, cadence/length counter and registered buzzer pin
    always_ff @(posedge _500Hz or posedge CR) begin
        if (CR) begin
            r_cnt    <= 16'd0;
            r_tone   <= 2'd0;
            r_low    <= 1'b0;
            r_buzzer <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nx;
            r_tone   <= w_tone_nx;
            r_low    <= w_low_nx;
            r_buzzer <= w_buzz_nx;
        end
    end

    assign Buzzer  = r_buzzer;
    assign Source  = r_state;
    assign Ringing = r_ringing;

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Bench for buzzer_scheduler: table vectors, directed corner sequences and
// random stimulus checked against a behavioural model every cycle.
module tb_buzzer_scheduler;

    localparam int PIP = 250;
    localparam int BH  = 125;
    localparam int AS  = 60;
    localparam int CLK = 10;

    logic       clk;
    logic       CR;
    logic [7:0] Hour, Minute, Second, AlarmHour, AlarmMinute;
    logic       AlarmEn, Stop, KeyPress;
    logic       Buzzer;
    logic [1:0] Source;
    logic       Ringing;

    int n_tests = 0;
    int n_fail  = 0;
    bit model_on = 0;

    buzzer_scheduler dut (
        ._500Hz(clk), .CR(CR),
        .Hour(Hour), .Minute(Minute), .Second(Second),
        .AlarmHour(AlarmHour), .AlarmMinute(AlarmMinute),
        .AlarmEn(AlarmEn), .Stop(Stop), .KeyPress(KeyPress),
        .Buzzer(Buzzer), .Source(Source), .Ringing(Ringing)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Owner and time-in-owner; the waveform is derived arithmetically.
    int         m_own = 0;
    int         m_el  = 0;
    bit         m_low = 0;
    bit         m_ring = 0;
    int         m_rt = 0;
    logic [7:0] m_secq = 8'h00;
    bit         m_primed = 0;

    logic mt_tick, mt_chime, mt_low, mt_start, mt_end, mt_ringn;
    int   n_own;

    function automatic int next_owner(int own, int el, bit chime, bit ringn, bit key);
        if (chime) return 1;
        case (own)
            0: begin
                if (ringn) return 2;
                if (key) return 3;
                return 0;
            end
            1: if (el + 1 == PIP) return ringn ? 2 : 0;
            2: if (!ringn) return 0;
            3: if (el + 1 == 10) return 0;
            default: return 0;
        endcase
        return own;
    endfunction

    function automatic bit exp_buzz(int own, int el, bit low);
        case (own)
            1: return low ? ((el % 4) < 2) : ((el % 2) == 0);
            2: return ((el % (2 * BH)) < BH) && ((el % 2) == 0);
            3: return (el % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    assign mt_tick  = m_primed && (Second != m_secq);
    assign mt_chime = mt_tick && (Minute == 8'h59) &&
                      (Second >= 8'h55) && (Second <= 8'h59);
    assign mt_low   = (Second != 8'h59);
    assign mt_start = mt_tick && (Second == 8'h00) && AlarmEn &&
                      (Hour == AlarmHour) && (Minute == AlarmMinute);
    assign mt_end   = m_ring && (Stop || !AlarmEn || (mt_tick && (m_rt + 1 >= AS)));
    assign mt_ringn = mt_end ? 1'b0 : (mt_start ? 1'b1 : m_ring);
    assign n_own    = next_owner(m_own, m_el, mt_chime, mt_ringn, KeyPress);

    always @(posedge clk or posedge CR) begin
        if (CR) begin
            m_own <= 0; m_el <= 0; m_low <= 0; m_ring <= 0;
            m_rt <= 0; m_secq <= 8'h00; m_primed <= 0;
        end else begin
            m_own    <= n_own;
            m_el     <= ((n_own != m_own) || mt_chime) ? 0 : m_el + 1;
            m_low    <= mt_chime ? mt_low : m_low;
            m_ring   <= mt_ringn;
            m_secq   <= Second;
            m_primed <= 1;
            if (mt_start) m_rt <= 0;
            else if (m_ring && mt_tick) m_rt <= m_rt + 1;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("model_src", int'(Source), m_own);
            check("model_buzz", int'(Buzzer), int'(exp_buzz(m_own, m_el, m_low)));
            check("model_ring", int'(Ringing), int'(m_ring));
        end
    end

    // ---------------- helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic bit exp_pat(int mode, int k);
        if (mode == 0) return (k % 4) < 2;
        return (k % 2) == 0;
    endfunction

    // Run length of Source==src from the next edge, with tone pattern check
    task automatic measure(input logic [1:0] src, input int mode,
                           output int len, output bit ok);
        len = 0;
        ok = 1;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            KeyPress = 0;
            if (Source != src) break;
            if (Buzzer !== exp_pat(mode, len)) ok = 0;
            len++;
        end
    endtask

    function automatic logic [7:0] bcd(int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    typedef struct {
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s0;
        logic [7:0] s1;
        int         len;
        bit         low;
    } vec_t;

    vec_t vecs[7];
    logic [7:0] rsec[8];

    initial begin
        int len;
        bit ok;

        vecs[0] = '{8'h12, 8'h59, 8'h54, 8'h55, PIP, 1'b1};
        vecs[1] = '{8'h12, 8'h59, 8'h58, 8'h59, PIP, 1'b0};
        vecs[2] = '{8'h13, 8'h00, 8'h59, 8'h00, 0,   1'b0};
        vecs[3] = '{8'h12, 8'h58, 8'h54, 8'h55, 0,   1'b1};
        vecs[4] = '{8'h12, 8'h59, 8'h56, 8'h57, PIP, 1'b1};
        vecs[5] = '{8'h12, 8'h59, 8'h50, 8'h51, 0,   1'b1};
        vecs[6] = '{8'h23, 8'h59, 8'h57, 8'h58, PIP, 1'b1};
        rsec = '{8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59, 8'h00, 8'h01};

        CR = 0; Hour = 0; Minute = 0; Second = 0;
        AlarmHour = 8'h99; AlarmMinute = 8'h99;
        AlarmEn = 0; Stop = 0; KeyPress = 0;
        #3 CR = 1;
        #1 model_on = 1;
        cyc(3);
        check("reset_buzzer", int'(Buzzer), 0);
        check("reset_source", int'(Source), 0);
        check("reset_ringing", int'(Ringing), 0);
        #2 CR = 0;
        cyc(5);

        // chime rule table
        for (int i = 0; i < 7; i++) begin
            Hour = vecs[i].h; Minute = vecs[i].m; Second = vecs[i].s0;
            cyc(300);
            Second = vecs[i].s1;
            measure(2'd1, vecs[i].low ? 0 : 1, len, ok);
            check($sformatf("vec%0d_len", i), len, vecs[i].len);
            if (vecs[i].len > 0) check($sformatf("vec%0d_pat", i), int'(ok), 1);
            check($sformatf("vec%0d_after", i), int'(Source), 0);
        end

        // alarm session: cadence and 60-second limit
        AlarmHour = 8'h07; AlarmMinute = 8'h30; AlarmEn = 1;
        Hour = 8'h07; Minute = 8'h29; Second = 8'h59;
        cyc(300);
        Minute = 8'h30; Second = 8'h00;
        @(negedge clk);
        check("alarm_ring", int'(Ringing), 1);
        check("alarm_src", int'(Source), 2);
        check("alarm_first_buzz", int'(Buzzer), 1);
        ok = 1;
        for (int k = 1; k < 500; k++) begin
            @(negedge clk);
            if (Buzzer !== (((k % 250) < 125) && ((k % 2) == 0))) ok = 0;
            if (Source != 2) ok = 0;
        end
        check("alarm_cadence", int'(ok), 1);
        for (int s = 1; s < 60; s++) begin
            Second = bcd(s);
            cyc(5);
        end
        check("alarm_59_ticks", int'(Ringing), 1);
        Minute = 8'h31; Second = 8'h00;
        @(negedge clk);
        check("alarm_60_ring", int'(Ringing), 0);
        check("alarm_60_src", int'(Source), 0);

        // chime preempts a ringing alarm, then Stop
        AlarmMinute = 8'h59;
        Minute = 8'h58; Second = 8'h59;
        cyc(300);
        Minute = 8'h59; Second = 8'h00;
        @(negedge clk);
        check("pre_alarm_src", int'(Source), 2);
        cyc(20);
        Second = 8'h54;
        cyc(20);
        Second = 8'h55;
        measure(2'd1, 0, len, ok);
        check("pre_pip_len", len, PIP);
        check("pre_pip_pat", int'(ok), 1);
        check("pre_back_src", int'(Source), 2);
        check("pre_held_ring", int'(Ringing), 1);
        cyc(10);
        Stop = 1;
        @(negedge clk);
        Stop = 0;
        check("stop_ring", int'(Ringing), 0);
        check("stop_src", int'(Source), 0);

        // key click in idle, key press ignored during a pip
        AlarmEn = 0;
        Hour = 8'h10; Minute = 8'h10; Second = 8'h10;
        cyc(300);
        KeyPress = 1;
        measure(2'd3, 1, len, ok);
        check("click_len", len, 10);
        check("click_pat", int'(ok), 1);
        Hour = 8'h12; Minute = 8'h59; Second = 8'h54;
        cyc(300);
        Second = 8'h55;
        len = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            KeyPress = 0;
            if (Source != 1) break;
            len++;
            if (len == 20) KeyPress = 1;
        end
        check("key_in_pip_len", len, PIP);
        check("key_in_pip_after", int'(Source), 0);

        // asynchronous reset mid-pip, no tick on first post-release sample
        Second = 8'h54;
        cyc(300);
        Second = 8'h55;
        cyc(50);
        check("cr_pre_src", int'(Source), 1);
        #2 CR = 1;
        #1;
        check("cr_async_buzz", int'(Buzzer), 0);
        check("cr_async_src", int'(Source), 0);
        check("cr_async_ring", int'(Ringing), 0);
        @(negedge clk);
        #2 CR = 0;
        ok = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (Source != 0) ok = 0;
        end
        check("cr_no_tick", int'(ok), 1);
        Second = 8'h56;
        @(negedge clk);
        check("cr_tick_after", int'(Source), 1);
        cyc(300);

        // random stimulus against the model
        Hour = 8'h07; AlarmHour = 8'h07; AlarmMinute = 8'h59; AlarmEn = 1;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            KeyPress = (($urandom % 20) == 0);
            Stop = (($urandom % 300) == 0);
            if (($urandom % 60) == 0) AlarmEn = (($urandom % 8) != 0);
            if (($urandom % 30) == 0) begin
                Minute = (($urandom % 2) == 0) ? 8'h59 : 8'h58;
                Second = rsec[$urandom_range(0, 7)];
            end
            if (($urandom % 1500) == 0) begin
                #2 CR = 1;
                @(negedge clk);
                #2 CR = 0;
            end
        end
        Stop = 0; KeyPress = 0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/buzzer_scheduler.md
# buzzer_scheduler

Single-buzzer controller for the clock/calendar. It shares one piezo output between three requesters: the hourly time-signal chime, the user alarm and key-click feedback. The block sits after the BCD time counters and the alarm-setting registers and owns the only `Buzzer` pin. It sequences pip and beep cadences and generates the tone waveform itself.

## Interface
- `PIP_CYCLES`, 250: length of one chime pip in clock cycles (0.5 s at 500 Hz).
- `BEEP_HALF`, 125: alarm cadence half-period in cycles (tone on 125, off 125).
- `ALARM_SECONDS`, 60: maximum alarm duration, counted in Second changes.
- `CLICK_CYCLES`, 10: key-click length in cycles.
- `_500Hz`  in  1  the block's single clock; all logic on its rising edge.
- `CR`  in  1  reset, asynchronous, active-high.
- `Hour`, `Minute`, `Second`  in  8 each  current time, BCD, synchronous to `_500Hz`.
- `AlarmHour`, `AlarmMinute`  in  8 each  alarm setting, BCD.
- `AlarmEn`  in  1  alarm armed.
- `Stop`  in  1  level; silences a ringing alarm.
- `KeyPress`  in  1  one-cycle pulse per debounced key press.
- `Buzzer`  out  1  registered tone waveform.
- `Source`  out  2  current owner: 0 idle, 1 chime, 2 alarm, 3 click.
- `Ringing`  out  1  alarm session active, including while preempted.

## Operation
- Second tick: `sec_q` registers `Second`. `tick` = (`Second` != `sec_q`) and `primed`. `primed` clears on reset and sets one cycle after reset release, so the first post-reset sample never ticks.
- Chime request: on a tick with `Minute`==8'h59 and new `Second` in {8'h55,8'h56,8'h57,8'h58}, request one low pip. With `Second`==8'h59, request one high pip. Each pip lasts `PIP_CYCLES`.
- Alarm session: starts on a tick with new `Second`==8'h00, `Hour`==`AlarmHour`, `Minute`==`AlarmMinute` and `AlarmEn`=1. Sets `Ringing`.
  - Ends on any of: `Stop`=1; `AlarmEn`=0; `ALARM_SECONDS` ticks elapsed since start. Clears `Ringing` the following cycle.
  - Session counters run while the alarm is preempted.
- Click request: a `KeyPress` while FSM is IDLE starts a click. A `KeyPress` in any other state is dropped and never queued.
- Arbiter FSM states: IDLE, CHIME, ALARM, CLICK. Priority is chime > alarm > click.
  - IDLE → CHIME on chime request; → ALARM if `Ringing`; → CLICK on `KeyPress`.
  - ALARM or CLICK → CHIME on chime request. A preempted click is abandoned.
  - CHIME → ALARM when the pip ends and `Ringing`=1, otherwise → IDLE.
  - CLICK → IDLE after `CLICK_CYCLES`.
  - ALARM → IDLE when the session ends.
- A chime request arriving while in CHIME restarts the pip with the new pitch. This is not reachable with real time, but it is required.
- Tone generation: 2-bit `tone_cnt` clears on each state entry and increments every cycle.
  - High tone: `Buzzer` = 1,0,1,0,… (250 Hz).
  - Low tone: `Buzzer` = 1,1,0,0,… (125 Hz).
  - Alarm and click use high tone. Alarm output is gated by the cadence counter: tone phase for `BEEP_HALF` cycles, silent (0) for `BEEP_HALF` cycles, starting with tone. The cadence restarts on every ALARM entry.
  - `Buzzer`=0 in IDLE.

## Timing
- Reset values: `Buzzer`=0, `Source`=0, `Ringing`=0, FSM IDLE, all counters 0, `sec_q`=8'h00, `primed`=0.
- Latency: a tick or `KeyPress` seen in cycle t gives state and `Source` updated at edge t+1. The first `Buzzer`=1 appears at edge t+1.
- A pip occupies exactly `PIP_CYCLES` cycles of `Source`=1.
- `Stop` and `AlarmEn` drop are sampled each cycle, with a 1-cycle response.
- A session end and a chime request in the same cycle are both honoured: enter CHIME, then return to IDLE.
- `CR` asserted mid-activity forces all reset values immediately, with no resumption after release.

## Test plan
- Time 12:59:54→12:59:55 → `Source`=1 for 250 cycles, `Buzzer` pattern 1100 repeating, then `Source`=0.
- 12:59:58→12:59:59 → a 250-cycle high pip with pattern 10 repeating. Then 13:00:00 produces no chime.
- `AlarmHour`=8'h07, `AlarmMinute`=8'h30, `AlarmEn`=1, time 07:29:59→07:30:00 → `Ringing`=1 and `Source`=2 with 125 cycles of tone, 125 silent. `Ringing` clears after 60 ticks.
- Ringing alarm at 07:59:54 → chime preempts (`Source`=1) at :55, returns to `Source`=2 between pips with `Ringing` held. `Stop` pulse → `Ringing`=0 next cycle.
- `KeyPress` in IDLE → 10-cycle click. `KeyPress` during a pip → ignored, `Source` stays 1.
- `CR` pulsed mid-pip → `Buzzer`=0, `Source`=0 asynchronously. The first post-release sample raises no tick even if `Second`=8'h55.
